seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter NUM_CH, default 2: number of independent serial input channels, legal range 1..8.
REQ-003 SHALL have parameter OVERLAP, default 1: 1 lets successive matches share bits; 0 requires PAT_W fresh bits after each match.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port din, input, NUM_CH bits: one serial data bit per channel.
REQ-007 SHALL have port din_valid, input, 1 bit: din is sampled on this edge, for all channels.
REQ-008 SHALL have port pat_load, input, 1 bit: loads pat_in as the new pattern.
REQ-009 SHALL have port pat_in, input, PAT_W bits: the pattern; MSB is the first bit received.
REQ-010 SHALL have port y, output, NUM_CH bits: registered, Moore-style match pulse per channel.
REQ-011 SHALL have port match_cnt, output, NUM_CH*8 bits: per-channel match count; channel c occupies bits [8c+7:8c].

Function
REQ-012 SHALL keep, per channel, a PAT_W-bit history shift register and a fill counter of width clog2(PAT_W+1).
REQ-013 SHALL, on an edge with din_valid=1 and pat_load=0, shift din[c] into the history LSB and increment fill, saturating at PAT_W.
REQ-014 SHALL detect a match on channel c when fill reaches PAT_W and the updated history equals the pattern.
REQ-015 SHALL drive y[c] high for exactly one cycle after the edge that completes a match; otherwise y[c]=0.
REQ-016 SHALL hold history, fill and y=0 on edges with din_valid=0; a match is never re-reported while the channel is idle.
REQ-017 SHALL, when OVERLAP=1, keep history and fill=PAT_W after a match, so back-to-back valid bits can match again on the next edge.
REQ-018 SHALL, when OVERLAP=0, clear fill to 0 on the matching edge.
REQ-019 SHALL, on an edge with pat_load=1, store pat_in, clear every history and fill, force y to 0 next cycle, and discard din on that edge.
REQ-020 SHALL treat pat_load as having priority over din_valid whenever both are asserted together.
REQ-021 SHALL make the first detection possible no earlier than PAT_W valid bits after a load or reset.
REQ-022 SHALL keep channels fully independent apart from the shared pattern and shared din_valid.

Reset
REQ-023 SHALL, while reset=0, asynchronously clear y, every history and fill, and match_cnt, and load the pattern register with all zeros.
REQ-024 SHALL resume sampling on the first rising edge after reset deasserts; a match in progress at reset is lost.

Configuration
REQ-025 SHALL, with macro SEQ_DET_COUNT_EN defined, increment match_cnt[c] on every match edge, saturating at 255 and clearing on pat_load.
REQ-026 SHALL, without SEQ_DET_COUNT_EN, keep match_cnt present but tied to 0 and build no counter logic.

Structure
REQ-027 SHALL place the PAT_W and NUM_CH bound constants, the counter width (8) and the fill-width function in package seq_det_pkg.
REQ-028 SHALL place one channel's history, fill, match logic, y flop and counter in sub-module seq_det_lane, instantiated NUM_CH times from a generate loop.

Verification
REQ-029 SHALL cover: reset low mid-stream with y=1 -> y, fill and match_cnt are 0 immediately without a clock edge; after release, the next match needs 4 new valid bits.
REQ-030 SHALL cover: PAT_W=4, OVERLAP=1, pattern 1011, ch0 stream 1011011 on consecutive valid edges -> y[0] pulses after bits 4 and 7; match_cnt[0]=2.
REQ-031 SHALL cover: the same stream with OVERLAP=0 -> a single pulse after bit 4; stream 10111011 -> pulses after bits 4 and 8.
REQ-032 SHALL cover: din_valid gaps of 3 cycles inserted inside the pattern 1011 -> one match pulse; y stays 0 during the gaps.
REQ-033 SHALL cover: pat_load with pat_in 0110 asserted together with a valid bit that would have completed 1011 -> no pulse, din discarded, the new pattern matches after 4 further bits.
REQ-034 SHALL cover: NUM_CH=2, ch0 fed 1011 and ch1 fed 1010 -> only y[0] pulses; with SEQ_DET_COUNT_EN defined and 300 matches on ch0, match_cnt[0] saturates at 255.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parameterised serial pattern detector.
package seq_det_pkg;

  localparam int unsigned PAT_W_MIN  = 2;
  localparam int unsigned PAT_W_MAX  = 16;
  localparam int unsigned NUM_CH_MIN = 1;
  localparam int unsigned NUM_CH_MAX = 8;
  localparam int unsigned CNT_W      = 8;

  // Fill counter must represent 0..pat_w inclusive.
  function automatic int unsigned fill_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_lane.sv
// One detector channel: history shifter, fill counter, match pulse and optional
// saturating match counter (enabled by SEQ_DET_COUNT_EN).
module seq_det_lane
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W   = 4,
  parameter bit          OVERLAP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned FW = fill_w(PAT_W);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d, hist_shift;
  logic [FW-1:0]    fill_q, fill_d, fill_inc;
  logic             y_q, y_d;
  logic             match;

  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], din};
    fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    // Load wins over a simultaneous valid bit, so it also suppresses the match.
    match      = din_valid & ~pat_load & (fill_inc == FILL_FULL) & (hist_shift == pat);

    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = 1'b0;
    if (pat_load) begin
      hist_d = '0;
      fill_d = '0;
    end else if (din_valid) begin
      hist_d = hist_shift;
      fill_d = (match && !OVERLAP) ? '0 : fill_inc;
      y_d    = match;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
    end
  end

  assign y = y_q;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (pat_load) begin
      cnt_q <= '0;
    end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: rtl/seq_detector_param.sv
// Multi-channel serial pattern detector sharing one loadable pattern.
// Define SEQ_DET_COUNT_EN to build the per-channel saturating match counters.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W   = 4,
  parameter int unsigned NUM_CH  = 2,
  parameter bit          OVERLAP = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       din,
  input  logic                    din_valid,
  input  logic                    pat_load,
  input  logic [PAT_W-1:0]        pat_in,
  output logic [NUM_CH-1:0]       y,
  output logic [NUM_CH*CNT_W-1:0] match_cnt
);

  logic [PAT_W-1:0] pat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q <= '0;
    end else if (pat_load) begin
      pat_q <= pat_in;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    seq_det_lane #(
      .PAT_W  (PAT_W),
      .OVERLAP(OVERLAP)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .din      (din[c]),
      .din_valid(din_valid),
      .pat_load (pat_load),
      .pat      (pat_q),
      .y        (y[c]),
      .match_cnt(match_cnt[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: overlapping and non-overlapping instances driven in parallel.
module tb_seq_detector_param;

`ifdef SEQ_DET_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  din;
  logic        din_valid;
  logic        pat_load;
  logic [3:0]  pat_in;
  logic [1:0]  y_ov, y_no;
  logic [15:0] cnt_ov, cnt_no;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .NUM_CH(2), .OVERLAP(1'b1)) u_ov (
    .clk(clk), .reset(rst_n), .din(din), .din_valid(din_valid), .pat_load(pat_load),
    .pat_in(pat_in), .y(y_ov), .match_cnt(cnt_ov)
  );

  seq_detector_param #(.PAT_W(4), .NUM_CH(2), .OVERLAP(1'b0)) u_no (
    .clk(clk), .reset(rst_n), .din(din), .din_valid(din_valid), .pat_load(pat_load),
    .pat_in(pat_in), .y(y_no), .match_cnt(cnt_no)
  );

  typedef struct {
    logic [1:0] y_ov;
    logic [1:0] y_no;
    logic [7:0] c_ov;   // ch0 count if counters were built
    logic [7:0] c_no;
    string      name;
  } exp_t;

  typedef struct {
    logic [1:0] din;
    logic       valid;
    logic       load;
    logic [3:0] pat;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] d, input logic v, input logic l, input logic [3:0] p,
                      input exp_t e);
    exp_t got;
    din = d; din_valid = v; pat_load = l; pat_in = p;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check({got.name, "_y_ov"}, {30'd0, y_ov}, {30'd0, got.y_ov});
      check({got.name, "_y_no"}, {30'd0, y_no}, {30'd0, got.y_no});
      check({got.name, "_cnt_ov"}, {16'd0, cnt_ov}, {24'd0, CNT_EN ? got.c_ov : 8'd0});
      check({got.name, "_cnt_no"}, {16'd0, cnt_no}, {24'd0, CNT_EN ? got.c_no : 8'd0});
    end
  endtask

  function automatic exp_t mk(input logic [1:0] yo, input logic [1:0] yn, input int co,
                              input int cn, input string nm);
    exp_t e;
    e.y_ov = yo; e.y_no = yn; e.c_ov = 8'(co); e.c_no = 8'(cn); e.name = nm;
    return e;
  endfunction

  task automatic add(input logic [1:0] d, input logic v, input logic l, input logic [3:0] p,
                     input logic [1:0] yo, input logic [1:0] yn, input int co, input int cn,
                     input string nm);
    vec_t r;
    r.din = d; r.valid = v; r.load = l; r.pat = p;
    r.e = mk(yo, yn, co, cn, nm);
    vecs.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    din = '0; din_valid = 1'b0; pat_load = 1'b0; pat_in = '0;
    rst_n = 1'b0;
    #2;
    check("reset_y_ov", {30'd0, y_ov}, 32'd0);
    check("reset_cnt_ov", {16'd0, cnt_ov}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Overlapping stream 1011011 on ch0, 1010100 on ch1.
    add(2'b11, 1, 1, 4'b1011, 2'b00, 2'b00, 0, 0, "s1_load");
    add(2'b11, 1, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "s1_b1");
    add(2'b00, 1, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "s1_b2");
    add(2'b11, 1, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "s1_b3");
    add(2'b01, 1, 0, 4'b0000, 2'b01, 2'b01, 1, 1, "s1_b4");
    add(2'b10, 1, 0, 4'b0000, 2'b00, 2'b00, 1, 1, "s1_b5");
    add(2'b01, 1, 0, 4'b0000, 2'b00, 2'b00, 1, 1, "s1_b6");
    add(2'b01, 1, 0, 4'b0000, 2'b01, 2'b00, 2, 1, "s1_b7");
    // Stream 10111011: both modes pulse after bits 4 and 8.
    add(2'b11, 1, 1, 4'b1011, 2'b00, 2'b00, 0, 0, "s2_load");
    add(2'b01, 1, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "s2_b1");
    add(2'b00, 1, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "s2_b2");
    add(2'b01, 1, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "s2_b3");
    add(2'b01, 1, 0, 4'b0000, 2'b01, 2'b01, 1, 1, "s2_b4");
    add(2'b01, 1, 0, 4'b0000, 2'b00, 2'b00, 1, 1, "s2_b5");
    add(2'b00, 1, 0, 4'b0000, 2'b00, 2'b00, 1, 1, "s2_b6");
    add(2'b01, 1, 0, 4'b0000, 2'b00, 2'b00, 1, 1, "s2_b7");
    add(2'b01, 1, 0, 4'b0000, 2'b01, 2'b01, 2, 2, "s2_b8");
    // 1011 with 3-cycle valid gaps; din toggled during gaps must be ignored.
    add(2'b11, 1, 1, 4'b1011, 2'b00, 2'b00, 0, 0, "g_load");
    add(2'b01, 1, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "g_b1");
    for (int i = 0; i < 3; i++) add(2'b11, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "g_gap1");
    add(2'b00, 1, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "g_b2");
    for (int i = 0; i < 3; i++) add(2'b10, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "g_gap2");
    add(2'b01, 1, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "g_b3");
    for (int i = 0; i < 3; i++) add(2'b00, 0, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "g_gap3");
    add(2'b01, 1, 0, 4'b0000, 2'b01, 2'b01, 1, 1, "g_b4");
    for (int i = 0; i < 3; i++) add(2'b01, 0, 0, 4'b0000, 2'b00, 2'b00, 1, 1, "g_idle");
    // Load of 0110 collides with the bit that would complete 1011.
    add(2'b11, 1, 1, 4'b1011, 2'b00, 2'b00, 0, 0, "p_load");
    add(2'b01, 1, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "p_b1");
    add(2'b00, 1, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "p_b2");
    add(2'b01, 1, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "p_b3");
    add(2'b01, 1, 1, 4'b0110, 2'b00, 2'b00, 0, 0, "p_collide");
    add(2'b00, 1, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "p_n1");
    add(2'b01, 1, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "p_n2");
    add(2'b01, 1, 0, 4'b0000, 2'b00, 2'b00, 0, 0, "p_n3");
    add(2'b00, 1, 0, 4'b0000, 2'b01, 2'b01, 1, 1, "p_n4");

    foreach (vecs[i]) step(vecs[i].din, vecs[i].valid, vecs[i].load, vecs[i].pat, vecs[i].e);

    // Asynchronous reset while y is high.
    step(2'b00, 1, 1, 4'b1011, mk(2'b00, 2'b00, 0, 0, "r_load"));
    step(2'b01, 1, 0, 4'b0000, mk(2'b00, 2'b00, 0, 0, "r_b1"));
    step(2'b00, 1, 0, 4'b0000, mk(2'b00, 2'b00, 0, 0, "r_b2"));
    step(2'b01, 1, 0, 4'b0000, mk(2'b00, 2'b00, 0, 0, "r_b3"));
    step(2'b01, 1, 0, 4'b0000, mk(2'b01, 2'b01, 1, 1, "r_b4"));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_y_ov", {30'd0, y_ov}, 32'd0);
    check("async_rst_y_no", {30'd0, y_no}, 32'd0);
    check("async_rst_cnt_ov", {16'd0, cnt_ov}, 32'd0);
    check("async_rst_cnt_no", {16'd0, cnt_no}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Pattern is now 0000: ch0 fed zeros needs four fresh bits, ch1 fed ones never matches.
    step(2'b10, 1, 0, 4'b0000, mk(2'b00, 2'b00, 0, 0, "ar_b1"));
    step(2'b10, 1, 0, 4'b0000, mk(2'b00, 2'b00, 0, 0, "ar_b2"));
    step(2'b10, 1, 0, 4'b0000, mk(2'b00, 2'b00, 0, 0, "ar_b3"));
    step(2'b10, 1, 0, 4'b0000, mk(2'b01, 2'b01, 1, 1, "ar_b4"));

    // Counter saturation: pattern 1111, 303 ones give 300 overlapping matches.
    step(2'b00, 1, 1, 4'b1111, mk(2'b00, 2'b00, 0, 0, "sat_load"));
    for (int i = 0; i < 303; i++) begin
      int co, cn;
      co = (i >= 3) ? ((i - 2 > 255) ? 255 : i - 2) : 0;
      cn = (i + 1) / 4;
      step(2'b01, 1, 0, 4'b0000,
           mk({1'b0, i >= 3}, {1'b0, (i % 4) == 3}, co, cn, "sat"));
    end
    check("sat_final_ov", {16'd0, cnt_ov}, CNT_EN ? 32'd255 : 32'd0);
    check("sat_final_no", {16'd0, cnt_no}, CNT_EN ? 32'd75 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
